// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single AXI-lite style bridge.
// One transaction at a time; all bridge-side outputs and acks are registered.
module mem_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] m_arwaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t      state, state_n;
    logic        grant_d, grant_d_n;
    logic        last_d, last_d_n;
    logic        pick_d;
    logic [31:0] arwaddr_n, wdata_n, i_rdata_n, d_rdata_n;
    logic        awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic        i_ack_n, d_ack_n;

    // D wins on a tie unless round-robin says I is due (I is due after reset).
    assign pick_d = d_req && (!i_req || (RR_EN == 0) || !last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_d   <= 1'b0;
            last_d    <= 1'b1;
            m_arwaddr <= 32'h0;
            m_wdata   <= 32'h0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            i_rdata   <= 32'h0;
            d_rdata   <= 32'h0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            state     <= state_n;
            grant_d   <= grant_d_n;
            last_d    <= last_d_n;
            m_arwaddr <= arwaddr_n;
            m_wdata   <= wdata_n;
            m_awvalid <= awvalid_n;
            m_wvalid  <= wvalid_n;
            m_bready  <= bready_n;
            m_arvalid <= arvalid_n;
            m_rready  <= rready_n;
            i_rdata   <= i_rdata_n;
            d_rdata   <= d_rdata_n;
            i_ack     <= i_ack_n;
            d_ack     <= d_ack_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_d_n = grant_d;
        last_d_n  = last_d;
        arwaddr_n = m_arwaddr;
        wdata_n   = m_wdata;
        awvalid_n = m_awvalid;
        wvalid_n  = m_wvalid;
        bready_n  = m_bready;
        arvalid_n = m_arvalid;
        rready_n  = m_rready;
        i_rdata_n = i_rdata;
        d_rdata_n = d_rdata;
        i_ack_n   = 1'b0;
        d_ack_n   = 1'b0;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_d_n = pick_d;
                    last_d_n  = pick_d;
                    if (pick_d) begin
                        arwaddr_n = d_addr;
                        wdata_n   = d_wdata;
                        if (d_we) begin
                            state_n   = WR_REQ;
                            awvalid_n = 1'b1;
                            wvalid_n  = 1'b1;
                        end else begin
                            state_n   = RD_ADDR;
                            arvalid_n = 1'b1;
                        end
                    end else begin
                        arwaddr_n = i_addr;
                        state_n   = RD_ADDR;
                        arvalid_n = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (m_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid) begin
                    rready_n = 1'b0;
                    state_n  = DONE;
                    if (grant_d) begin
                        d_rdata_n = m_rdata;
                        d_ack_n   = 1'b1;
                    end else begin
                        i_rdata_n = m_rdata;
                        i_ack_n   = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // Address and data channels complete independently, in any order.
                if (m_awready) awvalid_n = 1'b0;
                if (m_wready) wvalid_n = 1'b0;
                if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    bready_n = 1'b0;
                    state_n  = DONE;
                    d_ack_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with per-cycle compare,
// a delay-configurable bridge responder, and directed scenarios with literal expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ack, d_ack;
    logic [31:0] m_arwaddr, m_wdata, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    // fixed-priority instance with an always-ready bridge
    logic        f_i_req, f_d_req;
    logic [31:0] f_i_addr, f_d_addr;
    logic [31:0] f_i_rdata, f_d_rdata, f_m_arwaddr, f_m_wdata;
    logic        f_i_ack, f_d_ack;
    logic        f_m_awvalid, f_m_wvalid, f_m_bready, f_m_arvalid, f_m_rready;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_arwaddr(m_arwaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    mem_arbiter #(.RR_EN(0)) dut_fix (
        .clk(clk), .rst(rst),
        .i_req(f_i_req), .i_addr(f_i_addr), .i_rdata(f_i_rdata), .i_ack(f_i_ack),
        .d_req(f_d_req), .d_we(1'b0), .d_addr(f_d_addr), .d_wdata(32'h0),
        .d_rdata(f_d_rdata), .d_ack(f_d_ack),
        .m_arwaddr(f_m_arwaddr), .m_awvalid(f_m_awvalid), .m_awready(1'b1),
        .m_wdata(f_m_wdata), .m_wvalid(f_m_wvalid), .m_wready(1'b1),
        .m_bvalid(1'b1), .m_bready(f_m_bready),
        .m_arvalid(f_m_arvalid), .m_arready(1'b1),
        .m_rdata(32'h1357_9BDF), .m_rvalid(1'b1), .m_rready(f_m_rready)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // memory contents presented by the bridge
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2402_0001;
        return {a[15:0], ~a[15:0]};
    endfunction

    // bridge responder: each ready/valid appears once its channel has waited > delay cycles
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    always @(negedge clk) begin
        ar_cnt    = m_arvalid ? ar_cnt + 1 : 0;
        m_arready = m_arvalid && (ar_cnt > ar_dly);
        r_cnt     = m_rready ? r_cnt + 1 : 0;
        m_rvalid  = m_rready && (r_cnt > r_dly);
        m_rdata   = m_rvalid ? rd_word(m_arwaddr) : 32'h0;
        aw_cnt    = m_awvalid ? aw_cnt + 1 : 0;
        m_awready = m_awvalid && (aw_cnt > aw_dly);
        w_cnt     = m_wvalid ? w_cnt + 1 : 0;
        m_wready  = m_wvalid && (w_cnt > w_dly);
        b_cnt     = m_bready ? b_cnt + 1 : 0;
        m_bvalid  = m_bready && (b_cnt > b_dly);
    end

    // transaction-level reference: which channel is open, which port owns the transfer
    logic        mb_busy, mb_ack, mb_d, mb_last_d;
    logic        ar_o, r_o, aw_o, w_o, b_o;
    logic [31:0] mb_addr, mb_wdata, mb_irdata, mb_drdata;
    logic        mb_pick_d;
    int          grant_log[$];
    assign mb_pick_d = d_req && !(i_req && mb_last_d);

    always @(posedge clk) begin
        if (rst) begin
            mb_busy <= 0; mb_ack <= 0; mb_d <= 0; mb_last_d <= 1;
            ar_o <= 0; r_o <= 0; aw_o <= 0; w_o <= 0; b_o <= 0;
            mb_addr <= 0; mb_wdata <= 0; mb_irdata <= 0; mb_drdata <= 0;
        end else if (mb_ack) begin
            mb_ack  <= 0;
            mb_busy <= 0;
        end else if (!mb_busy) begin
            if (i_req || d_req) begin
                mb_busy   <= 1;
                mb_d      <= mb_pick_d;
                mb_last_d <= mb_pick_d;
                grant_log.push_back(mb_pick_d ? 1 : 0);
                mb_addr   <= mb_pick_d ? d_addr : i_addr;
                if (mb_pick_d) mb_wdata <= d_wdata;
                if (mb_pick_d && d_we) begin
                    aw_o <= 1;
                    w_o  <= 1;
                end else begin
                    ar_o <= 1;
                end
            end
        end else if (ar_o) begin
            if (m_arready) begin ar_o <= 0; r_o <= 1; end
        end else if (r_o) begin
            if (m_rvalid) begin
                r_o    <= 0;
                mb_ack <= 1;
                if (mb_d) mb_drdata <= rd_word(mb_addr);
                else      mb_irdata <= rd_word(mb_addr);
            end
        end else if (aw_o || w_o) begin
            if (m_awready) aw_o <= 0;
            if (m_wready)  w_o  <= 0;
            if ((!aw_o || m_awready) && (!w_o || m_wready)) b_o <= 1;
        end else if (b_o) begin
            if (m_bvalid) begin b_o <= 0; mb_ack <= 1; end
        end
    end

    // per-cycle compare plus activity counters for the directed checks
    logic chk_en = 1'b0;
    int   cnt_ar = 0, cnt_r = 0, cnt_aw = 0, cnt_w = 0, cnt_b = 0;
    int   cnt_iack = 0, cnt_dack = 0, cnt_overlap = 0;
    int   ack_log[$];
    always @(negedge clk) begin
        if (chk_en) begin
            check("arvalid", 32'(m_arvalid), 32'(ar_o));
            check("rready", 32'(m_rready), 32'(r_o));
            check("awvalid", 32'(m_awvalid), 32'(aw_o));
            check("wvalid", 32'(m_wvalid), 32'(w_o));
            check("bready", 32'(m_bready), 32'(b_o));
            check("i_ack", 32'(i_ack), 32'(mb_ack && !mb_d));
            check("d_ack", 32'(d_ack), 32'(mb_ack && mb_d));
            check("i_rdata", i_rdata, mb_irdata);
            check("d_rdata", d_rdata, mb_drdata);
            check("arwaddr", m_arwaddr, mb_addr);
            if (w_o) check("wdata", m_wdata, mb_wdata);
            cnt_ar   += int'(m_arvalid);
            cnt_r    += int'(m_rready);
            cnt_aw   += int'(m_awvalid);
            cnt_w    += int'(m_wvalid);
            cnt_b    += int'(m_bready);
            cnt_iack += int'(i_ack);
            cnt_dack += int'(d_ack);
            if ((m_bready || m_arvalid) && (m_awvalid || m_wvalid)) cnt_overlap++;
            if (i_ack) ack_log.push_back(0);
            if (d_ack) ack_log.push_back(1);
        end
    end

    task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
        bit got;
        @(negedge clk);
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
        else begin i_req = 1; i_addr = addr; end
        lat = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // requester wanders off after the grant edge; latched values must hold
                if (is_d) begin d_addr = ~addr; d_wdata = ~wd; d_we = ~we; end
                else i_addr = ~addr;
            end
            if (is_d ? d_ack : i_ack) got = 1;
        end
        if (is_d) d_req = 0; else i_req = 0;
        check("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic port_loop(input bit is_d, input logic [31:0] base);
        int lat;
        for (int k = 0; k < 3; k++) do_req(is_d, 1'b0, base + 32'(k * 4), 32'h0, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0, g0, v, s_ar, s_r, s_aw, s_w, s_b, s_i, s_d, s_ov;
        bit seen;
        int order[$];
        rst = 1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        f_i_req = 0; f_d_req = 0; f_i_addr = 0; f_d_addr = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_ctrl", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, i_ack, d_ack}), 32'd0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_arwaddr", m_arwaddr, 32'h0);
        check("rst_wdata", m_wdata, 32'h0);
        rst = 0;

        // single I read, zero-wait bridge
        @(posedge clk); s_d = cnt_dack;
        do_req(0, 0, 32'h0000_0040, 32'h0, lat);
        check("i_read_lat", 32'(lat), 32'd3);
        check("i_read_data", i_rdata, 32'h2402_0001);
        check("i_read_addr", m_arwaddr, 32'h0000_0040);
        @(posedge clk);
        check("i_read_no_dack", 32'(cnt_dack - s_d), 32'd0);

        // D read to give d_rdata a non-zero value
        do_req(1, 0, 32'h0000_0200, 32'h0, lat);
        check("d_read_data", d_rdata, 32'h0200_FDFF);

        // D write with awready delayed 2 cycles
        aw_dly = 2;
        @(posedge clk);
        s_aw = cnt_aw; s_w = cnt_w; s_b = cnt_b; s_i = cnt_iack; s_d = cnt_dack; s_ov = cnt_overlap;
        do_req(1, 1, 32'h1000_0000, 32'hDEAD_BEEF, lat);
        @(posedge clk);
        check("wr_lat", 32'(lat), 32'd5);
        check("wr_awvalid_cycles", 32'(cnt_aw - s_aw), 32'd3);
        check("wr_wvalid_cycles", 32'(cnt_w - s_w), 32'd1);
        check("wr_bready_cycles", 32'(cnt_b - s_b), 32'd1);
        check("wr_bready_overlap", 32'(cnt_overlap - s_ov), 32'd0);
        check("wr_dack_count", 32'(cnt_dack - s_d), 32'd1);
        check("wr_iack_count", 32'(cnt_iack - s_i), 32'd0);
        check("wr_d_rdata_kept", d_rdata, 32'h0200_FDFF);
        check("wr_addr", m_arwaddr, 32'h1000_0000);
        check("wr_data", m_wdata, 32'hDEAD_BEEF);
        aw_dly = 0;

        // slow read data
        r_dly = 5;
        @(posedge clk);
        s_ar = cnt_ar; s_r = cnt_r;
        do_req(0, 0, 32'h0000_0300, 32'h0, lat);
        @(posedge clk);
        check("slow_rd_lat", 32'(lat), 32'd8);
        check("slow_rd_rready_cycles", 32'(cnt_r - s_r), 32'd6);
        check("slow_rd_arvalid_cycles", 32'(cnt_ar - s_ar), 32'd1);
        check("slow_rd_data", i_rdata, 32'h0300_FCFF);
        r_dly = 0;

        // round robin from reset with both ports requesting continuously
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        a0 = ack_log.size();
        g0 = grant_log.size();
        fork
            port_loop(0, 32'h0000_0500);
            port_loop(1, 32'h0000_0600);
        join
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            v = (a0 + k < ack_log.size()) ? ack_log[a0 + k] : -1;
            check("rr_ack_order", 32'(v), 32'(k % 2));
            v = (g0 + k < grant_log.size()) ? grant_log[g0 + k] : -1;
            check("rr_model_grant", 32'(v), 32'(k % 2));
        end

        // fixed priority: D first, then I
        @(negedge clk);
        f_i_req = 1; f_d_req = 1; f_i_addr = 32'h0000_0800; f_d_addr = 32'h0000_0700;
        for (int k = 0; k < 20 && order.size() < 2; k++) begin
            @(negedge clk);
            if (f_d_ack) begin order.push_back(1); f_d_req = 0; end
            if (f_i_ack) begin order.push_back(0); f_i_req = 0; end
        end
        f_i_req = 0; f_d_req = 0;
        check("fix_ack_count", 32'(order.size()), 32'd2);
        check("fix_first_d", 32'((order.size() > 0) ? order[0] : -1), 32'd1);
        check("fix_second_i", 32'((order.size() > 1) ? order[1] : -1), 32'd0);
        check("fix_d_rdata", f_d_rdata, 32'h1357_9BDF);
        check("fix_i_rdata", f_i_rdata, 32'h1357_9BDF);
        @(negedge clk);
        check("fix_idle_ctrl", 32'({f_m_arvalid, f_m_rready, f_m_awvalid, f_m_wvalid, f_m_bready}), 32'd0);
        check("fix_last_addr", f_m_arwaddr, 32'h0000_0800);
        check("fix_wdata", f_m_wdata, 32'h0);

        // reset while waiting for the write response
        b_dly = 3;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h2000_0000; d_wdata = 32'h1234_5678;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_bready) begin seen = 1; break; end
        end
        check("abort_bready_seen", 32'(seen), 32'd1);
        rst = 1; d_req = 0;
        @(negedge clk);
        check("abort_ctrl_cleared", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, i_ack, d_ack}), 32'd0);
        rst = 0; b_dly = 0;
        @(posedge clk); s_d = cnt_dack;
        repeat (5) @(posedge clk);
        check("abort_no_dack", 32'(cnt_dack - s_d), 32'd0);
        do_req(1, 1, 32'h2000_0010, 32'hCAFE_F00D, lat);
        check("post_abort_wr_lat", 32'(lat), 32'd3);
        check("post_abort_d_rdata", d_rdata, 32'h0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin between ports, 0 = fixed D-port priority.
REQ-002 SHALL have port clk, input, 1, meaning single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-004 SHALL have I-port (fetch, read-only) ports:
  i_req in 1, request;
  i_addr in 32, address;
  i_rdata out 32, read data;
  i_ack out 1, done pulse.
REQ-005 SHALL have D-port ports:
  d_req in 1, request;
  d_we in 1, 1 = write;
  d_addr in 32, address;
  d_wdata in 32, write data;
  d_rdata out 32, read data;
  d_ack out 1, done pulse.
REQ-006 SHALL have bridge-side ports:
  m_arwaddr out 32, shared read/write address;
  m_awvalid out 1; m_awready in 1;
  m_wdata out 32; m_wvalid out 1; m_wready in 1;
  m_bvalid in 1; m_bready out 1;
  m_arvalid out 1; m_arready in 1;
  m_rdata in 32; m_rvalid in 1; m_rready out 1.

Function
REQ-007 SHALL run one transaction at a time, because m_arwaddr is shared by reads and writes.
REQ-008 SHALL use states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; all bridge-side outputs registered.
REQ-009 IDLE: no request -> stay. Otherwise grant one port, latch its addr/we/wdata into m_arwaddr/m_wdata, and go to RD_ADDR (read) or WR_REQ (write); I-port is always read.
REQ-010 Both requests in the same IDLE cycle:
  RR_EN=0 -> D wins;
  RR_EN=1 -> the port not granted last wins; after reset, D is treated as last granted, so I wins first.
REQ-011 RD_ADDR: m_arvalid=1 until the cycle m_arvalid&&m_arready, then -> RD_DATA with m_arvalid=0.
REQ-012 RD_DATA: m_rready=1. On m_rvalid: capture m_rdata into the granted port's rdata register, m_rready=0, -> DONE.
REQ-013 WR_REQ: m_awvalid and m_wvalid both asserted on entry, and each drops independently after its own handshake. When both handshakes are done (same or different cycles) -> WR_RESP.
REQ-014 WR_RESP: m_bready=1. On m_bvalid -> DONE, m_bready=0.
REQ-015 DONE: lasts exactly one cycle; pulse the granted port's ack for that cycle only; -> IDLE; requests not sampled in DONE.
REQ-016 Requesters SHALL deassert req by the edge ending the ack cycle; a req still high in IDLE is a new request.
REQ-017 i_rdata/d_rdata SHALL hold the last captured value until the next read completion on that port; a write never alters d_rdata.
REQ-018 Minimum latency with zero-wait bridge:
  read: req high at edge N -> m_arvalid at N+1 -> rdata captured at N+2 -> ack at N+3;
  write: ack at N+3.
REQ-019 Latched address/data SHALL ignore requester changes after the grant edge.
REQ-020 The ack pulse SHALL go only to the granted port; the other port's req is serviced in a later IDLE.

Reset
REQ-021 rst=1 at an edge SHALL force: state IDLE; all m_*valid/m_*ready outputs 0; i_ack=d_ack=0; i_rdata=d_rdata=m_arwaddr=m_wdata=0; RR pointer = D-last.
REQ-022 Reset mid-transaction SHALL abandon it with no ack; the bridge is reset by the same rst.

Verification
REQ-023 Single I read at 0x0000_0040, zero-wait bridge, m_rdata=0x2402_0001 -> m_arwaddr=0x40, i_ack 3 cycles after req, i_rdata=0x2402_0001, d_ack stays 0.
REQ-024 D write 0x1000_0000 <- 0xDEAD_BEEF; m_awready delayed 2 cycles, m_wready immediate -> m_wvalid drops after 1 cycle, m_awvalid held 3 cycles, m_bready only after both handshakes, single d_ack, d_rdata unchanged.
REQ-025 i_req and d_req (read) held together, RR_EN=1, from reset -> grant order I, D, I, D...; with RR_EN=0 -> D served first, I served afterwards.
REQ-026 m_rvalid delayed 5 cycles in RD_DATA -> m_rready held high, no ack until capture, m_arvalid low throughout.
REQ-027 rst asserted during WR_RESP -> next cycle all valids/readies 0, no d_ack, IDLE; a fresh d_req then completes normally.
